// File: rtl/wire_arith_pkg.sv
// Shared encodings and the width-generic add/sub helper for the wire arithmetic bank.
// The helper works on MAXW-bit words; callers zero-extend and keep the low WIDTH bits.
package wire_arith_pkg;

    localparam int MAXW = 32;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_MUL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic            flag;
        logic [MAXW-1:0] val;
    } arith_t;

    // flag = carry out of bit w (add) or borrow (sub); val is wrapped or clamped
    function automatic arith_t arith_op(input logic [MAXW-1:0] x,
                                        input logic [MAXW-1:0] y,
                                        input logic            sub,
                                        input logic            sat,
                                        input int unsigned     w);
        logic [MAXW:0] one;
        logic [MAXW:0] mask;
        logic [MAXW:0] raw;
        arith_t        r;
        one    = (MAXW+1)'(1);
        mask   = (one << w) - one;
        raw    = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r.flag = sub ? (x < y) : ((raw & ~mask) != '0);
        if (sat && r.flag)
            r.val = sub ? '0 : mask[MAXW-1:0];
        else
            r.val = raw[MAXW-1:0] & mask[MAXW-1:0];
        return r;
    endfunction

endpackage

// File: rtl/wire_arith_chan.sv
// One arithmetic channel: continuous add/sub, triggered accumulate, and a
// repeated-add multiplier sequenced by a small IDLE/RUN/DONE FSM.
module wire_arith_chan
    import wire_arith_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       mode_i,
    input  logic             start_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    mode_e            md;
    logic [WIDTH-1:0] opx, opy;
    logic             opsub;
    arith_t           ar;
    logic [WIDTH-1:0] sum;
    logic [MAXW-1:0]  unused_val;

    assign md = mode_e'(mode_i);

    // One shared adder: the FSM owns it while busy, otherwise the live mode does
    always_comb begin
        opx   = a_i;
        opy   = b_i;
        opsub = 1'b0;
        if (state_q != ST_IDLE) begin
            opx = acc_q;
            opy = a_q;
        end else if (md == MODE_ACC) begin
            opx = result_q;
            opy = a_i;
        end else begin
            opsub = (md == MODE_SUB);
        end
    end

    assign ar         = arith_op(MAXW'(opx), MAXW'(opy), opsub, SATURATE, WIDTH);
    assign sum        = ar.val[WIDTH-1:0];
    assign unused_val = ar.val;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (clear_i) begin
            state_d  = ST_IDLE;
            result_d = '0;
            acc_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (md)
                        MODE_ADD, MODE_SUB: begin
                            result_d = sum;
                            ovf_d    = ovf_q | ar.flag;
                        end
                        MODE_ACC: if (start_i) begin
                            result_d = sum;
                            ovf_d    = ovf_q | ar.flag;
                            done_d   = 1'b1;
                        end
                        MODE_MUL: if (start_i) begin
                            a_d     = a_i;
                            cnt_d   = b_i;
                            acc_d   = '0;
                            state_d = ST_RUN;
                        end
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        result_d = acc_q;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d = sum;
                        ovf_d = ovf_q | ar.flag;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q | (state_q == ST_DONE);
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/wire_arith_bank.sv
// Bank of NCH independent arithmetic channels between host wire/trigger endpoints.
// Channel k owns bits [k*WIDTH +: WIDTH] of the operand and result buses.
module wire_arith_bank
    import wire_arith_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic                 ti_clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] op_a,
    input  logic [NCH*WIDTH-1:0] op_b,
    input  logic [NCH*2-1:0]     mode,
    input  logic [NCH-1:0]       trig_start,
    input  logic [NCH-1:0]       trig_clear,
    output logic [NCH*WIDTH-1:0] result,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       ovf
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        wire_arith_chan #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE != 0)
        ) u_chan (
            .clk_i    (ti_clk),
            .rst_i    (rst),
            .a_i      (op_a[k*WIDTH +: WIDTH]),
            .b_i      (op_b[k*WIDTH +: WIDTH]),
            .mode_i   (mode[k*2 +: 2]),
            .start_i  (trig_start[k]),
            .clear_i  (trig_clear[k]),
            .result_o (result[k*WIDTH +: WIDTH]),
            .busy_o   (busy[k]),
            .done_o   (done[k]),
            .ovf_o    (ovf[k])
        );
    end

endmodule

// File: tb/tb_wire_arith_bank.sv
// Bench for wire_arith_bank: wrapping and saturating builds side by side on the
// same stimulus, each checked every cycle against an arithmetic reference model.
module tb_wire_arith_bank;
    localparam int NCH = 2;
    localparam int W   = 16;
    localparam longint MAXV = 65535;

    logic               ti_clk = 1'b0;
    logic               rst;
    logic [NCH*W-1:0]   op_a, op_b;
    logic [NCH*2-1:0]   mode;
    logic [NCH-1:0]     trig_start, trig_clear;
    logic [NCH*W-1:0]   res_w, res_s;
    logic [NCH-1:0]     busy_w, busy_s, done_w, done_s, ovf_w, ovf_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 ti_clk = ~ti_clk;

    wire_arith_bank #(.NCH(NCH), .WIDTH(W), .SATURATE(0)) u_wrap (
        .ti_clk(ti_clk), .rst(rst), .op_a(op_a), .op_b(op_b), .mode(mode),
        .trig_start(trig_start), .trig_clear(trig_clear),
        .result(res_w), .busy(busy_w), .done(done_w), .ovf(ovf_w));

    wire_arith_bank #(.NCH(NCH), .WIDTH(W), .SATURATE(1)) u_sat (
        .ti_clk(ti_clk), .rst(rst), .op_a(op_a), .op_b(op_b), .mode(mode),
        .trig_start(trig_start), .trig_clear(trig_clear),
        .result(res_s), .busy(busy_s), .done(done_s), .ovf(ovf_s));

    // Reference model: index [s][k], s=0 wrapping build, s=1 saturating build.
    // A multiply is tracked as "n edges since start" and its product computed directly.
    longint m_res[2][NCH];
    bit     m_ovf[2][NCH];
    bit     m_adone[2][NCH];
    bit     m_act[2][NCH];
    longint m_a[2][NCH], m_b[2][NCH], m_n[2][NCH];

    function automatic longint fit(input longint v, input bit sat);
        if (v < 0)    return sat ? 0 : v + MAXV + 1;
        if (v > MAXV) return sat ? MAXV : v - (MAXV + 1);
        return v;
    endfunction

    always @(posedge ti_clk) begin : model
        longint a, b, p;
        logic [1:0] md;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NCH; k++) begin
                a  = longint'(op_a[k*W +: W]);
                b  = longint'(op_b[k*W +: W]);
                md = mode[k*2 +: 2];
                m_adone[s][k] = 1'b0;
                if (rst || trig_clear[k]) begin
                    m_res[s][k] = 0;
                    m_ovf[s][k] = 1'b0;
                    m_act[s][k] = 1'b0;
                end else if (m_act[s][k]) begin
                    m_n[s][k]++;
                    if (m_n[s][k] <= m_b[s][k] && m_n[s][k] * m_a[s][k] > MAXV)
                        m_ovf[s][k] = 1'b1;
                    if (m_n[s][k] == m_b[s][k] + 1) begin
                        p = m_a[s][k] * m_b[s][k];
                        m_res[s][k] = (s == 1) ? ((p > MAXV) ? MAXV : p) : (p % (MAXV + 1));
                    end
                    if (m_n[s][k] == m_b[s][k] + 2) m_act[s][k] = 1'b0;
                end else begin
                    case (md)
                        2'b00: begin
                            m_ovf[s][k] |= (a + b > MAXV);
                            m_res[s][k] = fit(a + b, s == 1);
                        end
                        2'b01: begin
                            m_ovf[s][k] |= (a < b);
                            m_res[s][k] = fit(a - b, s == 1);
                        end
                        2'b10: if (trig_start[k]) begin
                            m_ovf[s][k] |= (m_res[s][k] + a > MAXV);
                            m_res[s][k] = fit(m_res[s][k] + a, s == 1);
                            m_adone[s][k] = 1'b1;
                        end
                        default: if (trig_start[k]) begin
                            m_act[s][k] = 1'b1;
                            m_n[s][k]   = 0;
                            m_a[s][k]   = a;
                            m_b[s][k]   = b;
                        end
                    endcase
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        string nm;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NCH; k++) begin
                nm = $sformatf("%s ch%0d", (s == 1) ? "sat" : "wrap", k);
                chk({nm, " result"}, (s == 1) ? 32'(res_s[k*W +: W]) : 32'(res_w[k*W +: W]),
                    32'(m_res[s][k]));
                chk({nm, " busy"}, (s == 1) ? 32'(busy_s[k]) : 32'(busy_w[k]), 32'(m_act[s][k]));
                chk({nm, " done"}, (s == 1) ? 32'(done_s[k]) : 32'(done_w[k]),
                    32'(m_adone[s][k] || (m_act[s][k] && m_n[s][k] == m_b[s][k] + 1)));
                chk({nm, " ovf"}, (s == 1) ? 32'(ovf_s[k]) : 32'(ovf_w[k]), 32'(m_ovf[s][k]));
            end
        end
    endtask

    task automatic tick();
        @(posedge ti_clk);
        @(negedge ti_clk);
        trig_start = '0;
        trig_clear = '0;
        check_all();
    endtask

    task automatic set_ch(input int k, input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
        mode[k*2 +: 2] = md;
        op_a[k*W +: W] = a;
        op_b[k*W +: W] = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int cnt, done_at;
        rst = 1'b1; op_a = '0; op_b = '0; mode = '0; trig_start = '0; trig_clear = '0;
        tick(); tick();
        chk("reset result", 32'(res_w), 32'd0);
        chk("reset flags", 32'({busy_w, done_w, ovf_w, busy_s, done_s, ovf_s}), 32'd0);
        rst = 1'b0;

        // add with carry, sticky ovf
        set_ch(0, 2'b00, 16'h1234, 16'h0001); set_ch(1, 2'b00, 16'h0, 16'h0);
        tick();
        chk("add 1235", 32'(res_w[15:0]), 32'h1235);
        chk("add no ovf", 32'(ovf_w[0]), 32'd0);
        set_ch(0, 2'b00, 16'hFFFF, 16'h0002);
        tick();
        chk("add wrap", 32'(res_w[15:0]), 32'h0001);
        chk("add sat", 32'(res_s[15:0]), 32'hFFFF);
        set_ch(0, 2'b00, 16'h0001, 16'h0001);
        tick();
        chk("ovf sticky", 32'(ovf_w[0]), 32'd1);

        // subtract with borrow, clear
        trig_clear = 2'b11; set_ch(0, 2'b00, 16'h0, 16'h0);
        tick();
        set_ch(1, 2'b01, 16'd5, 16'd9);
        tick();
        chk("sub sat", 32'(res_s[31:16]), 32'h0000);
        chk("sub ovf", 32'(ovf_s[1]), 32'd1);
        chk("sub wrap", 32'(res_w[31:16]), 32'hFFFC);
        trig_clear[1] = 1'b1;
        tick();
        chk("sub clr ovf", 32'(ovf_s[1]), 32'd0);
        tick();
        chk("sub ovf again", 32'(ovf_s[1]), 32'd1);

        // multiply 7*3, start while busy ignored
        trig_clear = 2'b11; set_ch(0, 2'b11, 16'd7, 16'd3); set_ch(1, 2'b00, 16'h0, 16'h0);
        tick();
        trig_start[0] = 1'b1;
        tick();
        cnt = 0; done_at = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_w[0]) cnt++;
            if (done_w[0]) done_at = cnt;
            if (i == 1) trig_start[0] = 1'b1;
            tick();
        end
        chk("mul busy cycles", 32'(cnt), 32'd5);
        chk("mul done cycle", 32'(done_at), 32'd5);
        chk("mul 21", 32'(res_w[15:0]), 32'd21);

        // multiply overflow, then b=0
        trig_clear = 2'b11; set_ch(0, 2'b11, 16'h8000, 16'd4);
        tick();
        trig_start[0] = 1'b1;
        tick();
        repeat (8) tick();
        chk("mul ovf wrap", 32'(res_w[15:0]), 32'h0000);
        chk("mul ovf sat", 32'(res_s[15:0]), 32'hFFFF);
        chk("mul ovf flags", 32'({ovf_w[0], ovf_s[0]}), 32'd3);
        set_ch(0, 2'b11, 16'h1234, 16'd0);
        trig_start[0] = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy_s[0]) cnt++;
            tick();
        end
        chk("mul b0 busy", 32'(cnt), 32'd2);
        chk("mul b0 result", 32'(res_s[15:0]), 32'd0);

        // accumulate from an ADD-preset value
        trig_clear = 2'b11; set_ch(0, 2'b00, 16'd10, 16'd0);
        tick();
        tick();
        set_ch(0, 2'b10, 16'd5, 16'd0);
        tick();
        chk("acc hold", 32'(res_w[15:0]), 32'd10);
        for (int i = 0; i < 3; i++) begin
            trig_start[0] = 1'b1;
            tick();
            chk("acc step", 32'(res_w[15:0]), 32'(10 + 5 * (i + 1)));
            chk("acc done", 32'(done_w[0]), 32'd1);
            tick();
        end
        trig_start[0] = 1'b1; trig_clear[0] = 1'b1;
        tick();
        chk("acc clr result", 32'(res_w[15:0]), 32'd0);
        chk("acc clr done", 32'(done_w[0]), 32'd0);

        // reset mid-multiply, ch1 keeps adding
        trig_clear = 2'b11; set_ch(0, 2'b11, 16'd3, 16'd100); set_ch(1, 2'b00, 16'd100, 16'd0);
        tick();
        trig_start[0] = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            set_ch(1, 2'b00, 16'd100, 16'(i));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst busy", 32'(busy_w[0]), 32'd0);
        chk("rst result", 32'(res_w[15:0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_ch(1, 2'b00, 16'd100, 16'(50 + i));
            tick();
        end
        chk("ch1 after rst", 32'(res_w[31:16]), 32'd154);

        // randomized traffic
        trig_clear = 2'b11;
        tick();
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < NCH; k++) begin
                logic [1:0] md;
                md = mode[k*2 +: 2];
                if ($urandom_range(0, 3) == 0) md = 2'($urandom_range(0, 3));
                set_ch(k, md,
                       ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40)),
                       (md == 2'b11) ? 16'($urandom_range(0, 12)) : 16'($urandom));
                if ($urandom_range(0, 7) == 0) op_a[k*W +: W] = 16'hFFF0 | 16'($urandom_range(0, 15));
                trig_start[k] = ($urandom_range(0, 3) == 0);
                trig_clear[k] = ($urandom_range(0, 15) == 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
